// File: rtl/id_ex_stage_pkg.sv
// Shared constants for the ID/EX stage: opcodes, forward-select codes, NOP
// encoding and small opcode-class helpers.
package id_ex_stage_pkg;

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_S    = 7'b0100011;
   localparam logic [6:0] OP_B    = 7'b1100011;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_LW   = 7'b0000011;

   // addi x0,x0,0 -- what an empty EX slot shows
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      NO_FWD  = 2'b00,
      EX_FWD  = 2'b01,
      MEM_FWD = 2'b10,
      WB_FWD  = 2'b11
   } fwd_sel_e;

   // Opcode classes that actually read rs1 (and may take forwarded data on A)
   function automatic logic uses_rs1(input logic [6:0] op);
      return (op == OP_R) || (op == OP_I) || (op == OP_S) ||
             (op == OP_B) || (op == OP_JALR) || (op == OP_LW);
   endfunction

   // Opcode classes that read rs2 (relevant for load-use detection)
   function automatic logic uses_rs2(input logic [6:0] op);
      return (op == OP_R) || (op == OP_S) || (op == OP_B);
   endfunction

   // Opcode classes whose operand B may be replaced by forwarded data
   function automatic logic fwd_b_allowed(input logic [6:0] op);
      return (op == OP_R) || (op == OP_B);
   endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle of all ID-side inputs, forwarding sources and EX-side outputs of the
// ID/EX pipeline register. The stage itself uses the slave modport.
interface id_ex_stage_if #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 16,
   parameter int CNT_W  = 32
);
   logic [31:0]       instr_id;
   logic [DATA_W-1:0] pc_id;
   logic [DATA_W-1:0] imm_id;
   logic [4:0]        rs1_id;
   logic [4:0]        rs2_id;
   logic [4:0]        rd_id;
   logic              we_rf_id;
   logic [CTRL_W-1:0] ctrl_id;
   logic [DATA_W-1:0] rd1_id;
   logic [DATA_W-1:0] rd2_id;
   logic [1:0]        forwardA;
   logic [1:0]        forwardB;
   logic [DATA_W-1:0] alu_result_ex;
   logic [DATA_W-1:0] wd_mem;
   logic [DATA_W-1:0] wd_wb;
   logic              flush;

   logic              stall;
   logic [31:0]       instr_ex;
   logic [DATA_W-1:0] pc_ex;
   logic [DATA_W-1:0] imm_ex;
   logic [DATA_W-1:0] rd1_ex;
   logic [DATA_W-1:0] rd2_ex;
   logic [4:0]        rs1_ex;
   logic [4:0]        rs2_ex;
   logic [4:0]        rd_ex;
   logic              we_rf_ex;
   logic [CTRL_W-1:0] ctrl_ex;
   logic              valid_ex;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  flush_cnt;

   modport slave (
      input  instr_id, pc_id, imm_id, rs1_id, rs2_id, rd_id, we_rf_id, ctrl_id,
             rd1_id, rd2_id, forwardA, forwardB, alu_result_ex, wd_mem, wd_wb, flush,
      output stall, instr_ex, pc_ex, imm_ex, rd1_ex, rd2_ex, rs1_ex, rs2_ex, rd_ex,
             we_rf_ex, ctrl_ex, valid_ex, stall_cnt, flush_cnt
   );

   modport master (
      output instr_id, pc_id, imm_id, rs1_id, rs2_id, rd_id, we_rf_id, ctrl_id,
             rd1_id, rd2_id, forwardA, forwardB, alu_result_ex, wd_mem, wd_wb, flush,
      input  stall, instr_ex, pc_ex, imm_ex, rd1_ex, rd2_ex, rs1_ex, rs2_ex, rd_ex,
             we_rf_ex, ctrl_ex, valid_ex, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// Gated 4:1 operand select: when the opcode class does not permit forwarding,
// the stale forward code is ignored and the RF read data passes through.
module operand_fwd_mux
   import id_ex_stage_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              en_i,
   input  fwd_sel_e          sel_i,
   input  logic [DATA_W-1:0] rf_i,
   input  logic [DATA_W-1:0] ex_i,
   input  logic [DATA_W-1:0] mem_i,
   input  logic [DATA_W-1:0] wb_i,
   output logic [DATA_W-1:0] op_o
);

   // Pick the newest producer of the operand, or the RF value
   always_comb begin
      op_o = rf_i;
      if (en_i) begin
         case (sel_i)
            EX_FWD:  op_o = ex_i;
            MEM_FWD: op_o = mem_i;
            WB_FWD:  op_o = wb_i;
            default: op_o = rf_i;
         endcase
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: operand forwarding, load-use hazard detection,
// bubble insertion on stall/flush and saturating stall/flush counters.
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 16,
   parameter int CNT_W  = 32
) (
   input logic         clk,
   input logic         rst,
   id_ex_stage_if.slave bus
);

   logic [6:0]        op_id;
   logic [6:0]        op_ex;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic              load_in_ex;
   logic              stall;

   logic [31:0]       instr_ex_q, instr_ex_d;
   logic [DATA_W-1:0] pc_ex_q, pc_ex_d;
   logic [DATA_W-1:0] imm_ex_q, imm_ex_d;
   logic [DATA_W-1:0] rd1_ex_q, rd1_ex_d;
   logic [DATA_W-1:0] rd2_ex_q, rd2_ex_d;
   logic [4:0]        rs1_ex_q, rs1_ex_d;
   logic [4:0]        rs2_ex_q, rs2_ex_d;
   logic [4:0]        rd_ex_q, rd_ex_d;
   logic              we_rf_ex_q, we_rf_ex_d;
   logic [CTRL_W-1:0] ctrl_ex_q, ctrl_ex_d;
   logic              valid_ex_q, valid_ex_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

   assign op_id = bus.instr_id[6:0];
   assign op_ex = instr_ex_q[6:0];

   operand_fwd_mux #(.DATA_W(DATA_W)) u_fwd_a (
      .en_i  (uses_rs1(op_id)),
      .sel_i (fwd_sel_e'(bus.forwardA)),
      .rf_i  (bus.rd1_id),
      .ex_i  (bus.alu_result_ex),
      .mem_i (bus.wd_mem),
      .wb_i  (bus.wd_wb),
      .op_o  (op_a)
   );

   operand_fwd_mux #(.DATA_W(DATA_W)) u_fwd_b (
      .en_i  (fwd_b_allowed(op_id)),
      .sel_i (fwd_sel_e'(bus.forwardB)),
      .rf_i  (bus.rd2_id),
      .ex_i  (bus.alu_result_ex),
      .mem_i (bus.wd_mem),
      .wb_i  (bus.wd_wb),
      .op_o  (op_b)
   );

   // A load in EX whose result the ID instruction needs cannot be forwarded
   // yet; the bubble it causes clears the condition, so the stall is one cycle.
   assign load_in_ex = valid_ex_q && we_rf_ex_q && (op_ex == OP_LW) && (rd_ex_q != '0);
   assign stall = load_in_ex &&
                  ((uses_rs1(op_id) && (bus.rs1_id == rd_ex_q)) ||
                   (uses_rs2(op_id) && (bus.rs2_id == rd_ex_q)));

   // Next EX contents: bubble by default, flush beats stall, else load ID
   always_comb begin
      instr_ex_d  = NOP;
      pc_ex_d     = '0;
      imm_ex_d    = '0;
      rd1_ex_d    = '0;
      rd2_ex_d    = '0;
      rs1_ex_d    = '0;
      rs2_ex_d    = '0;
      rd_ex_d     = '0;
      we_rf_ex_d  = 1'b0;
      ctrl_ex_d   = '0;
      valid_ex_d  = 1'b0;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (bus.flush) begin
         if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end else if (stall) begin
         if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end else begin
         instr_ex_d = bus.instr_id;
         pc_ex_d    = bus.pc_id;
         imm_ex_d   = bus.imm_id;
         rd1_ex_d   = op_a;
         rd2_ex_d   = op_b;
         rs1_ex_d   = bus.rs1_id;
         rs2_ex_d   = bus.rs2_id;
         rd_ex_d    = bus.rd_id;
         we_rf_ex_d = bus.we_rf_id;
         ctrl_ex_d  = bus.ctrl_id;
         valid_ex_d = 1'b1;
      end
   end

   // Pipeline register with asynchronous reset to an empty (NOP) slot
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_ex_q  <= NOP;
         pc_ex_q     <= '0;
         imm_ex_q    <= '0;
         rd1_ex_q    <= '0;
         rd2_ex_q    <= '0;
         rs1_ex_q    <= '0;
         rs2_ex_q    <= '0;
         rd_ex_q     <= '0;
         we_rf_ex_q  <= 1'b0;
         ctrl_ex_q   <= '0;
         valid_ex_q  <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         instr_ex_q  <= instr_ex_d;
         pc_ex_q     <= pc_ex_d;
         imm_ex_q    <= imm_ex_d;
         rd1_ex_q    <= rd1_ex_d;
         rd2_ex_q    <= rd2_ex_d;
         rs1_ex_q    <= rs1_ex_d;
         rs2_ex_q    <= rs2_ex_d;
         rd_ex_q     <= rd_ex_d;
         we_rf_ex_q  <= we_rf_ex_d;
         ctrl_ex_q   <= ctrl_ex_d;
         valid_ex_q  <= valid_ex_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign bus.stall     = stall;
   assign bus.instr_ex  = instr_ex_q;
   assign bus.pc_ex     = pc_ex_q;
   assign bus.imm_ex    = imm_ex_q;
   assign bus.rd1_ex    = rd1_ex_q;
   assign bus.rd2_ex    = rd2_ex_q;
   assign bus.rs1_ex    = rs1_ex_q;
   assign bus.rs2_ex    = rs2_ex_q;
   assign bus.rd_ex     = rd_ex_q;
   assign bus.we_rf_ex  = we_rf_ex_q;
   assign bus.ctrl_ex   = ctrl_ex_q;
   assign bus.valid_ex  = valid_ex_q;
   assign bus.stall_cnt = stall_cnt_q;
   assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage. Counters are built 3 bits wide so that
// saturation is reachable in a handful of hazards.
module tb_id_ex_stage;

   localparam int DATA_W = 32;
   localparam int CTRL_W = 16;
   localparam int CNT_W  = 3;

   localparam logic [6:0] R_OP   = 7'b0110011;
   localparam logic [6:0] S_OP   = 7'b0100011;
   localparam logic [6:0] LW_OP  = 7'b0000011;
   localparam logic [6:0] LUI_OP = 7'b0110111;

   logic clk;
   logic rst;
   int   tests_run;
   int   tests_failed;

   id_ex_stage_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus ();

   id_ex_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2);
      return {7'd0, rs2, rs1, 3'd0, rd, op};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic we, input logic [31:0] rd1,
                         input logic [31:0] rd2, input logic [1:0] fa, input logic [1:0] fb);
      bus.instr_id = mk(op, rd, rs1, rs2);
      bus.pc_id    = 32'h0000_1000 + {27'd0, rd};
      bus.imm_id   = 32'h0000_0100 + {27'd0, rd};
      bus.rs1_id   = rs1;
      bus.rs2_id   = rs2;
      bus.rd_id    = rd;
      bus.we_rf_id = we;
      bus.ctrl_id  = {9'd0, op};
      bus.rd1_id   = rd1;
      bus.rd2_id   = rd2;
      bus.forwardA = fa;
      bus.forwardB = fb;
   endtask

   task automatic test_reset();
      // lw x5 into EX, then dependent add in ID raises stall; reset drops it at once
      set_id(LW_OP, 5'd5, 5'd1, 5'd0, 1'b1, 32'h1, 32'h2, 2'b00, 2'b00);
      tick();
      set_id(R_OP, 5'd6, 5'd5, 5'd7, 1'b1, 32'h3, 32'h4, 2'b00, 2'b00);
      #1;
      tests_run++; if (bus.stall !== 1'b1) begin tests_failed++; $display("FAIL reset_pre_stall: got %b want 1", bus.stall); end
      rst = 1'b1;
      #1;
      tests_run++; if (bus.stall !== 1'b0) begin tests_failed++; $display("FAIL reset_stall: got %b want 0", bus.stall); end
      tests_run++; if (bus.valid_ex !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", bus.valid_ex); end
      tests_run++; if (bus.we_rf_ex !== 1'b0) begin tests_failed++; $display("FAIL reset_we: got %b want 0", bus.we_rf_ex); end
      tests_run++; if (bus.instr_ex !== 32'h0000_0013) begin tests_failed++; $display("FAIL reset_instr: got %h want 00000013", bus.instr_ex); end
      tests_run++; if (bus.rd_ex !== 5'd0) begin tests_failed++; $display("FAIL reset_rd: got %0d want 0", bus.rd_ex); end
      tests_run++; if (bus.rd1_ex !== 32'h0) begin tests_failed++; $display("FAIL reset_rd1: got %h want 0", bus.rd1_ex); end
      tests_run++; if (bus.ctrl_ex !== 16'h0) begin tests_failed++; $display("FAIL reset_ctrl: got %h want 0", bus.ctrl_ex); end
      tests_run++; if (bus.stall_cnt !== 3'd0 || bus.flush_cnt !== 3'd0) begin tests_failed++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", bus.stall_cnt, bus.flush_cnt); end
      rst = 1'b0;
      $display("[TB] reset: stall and EX cleared");
   endtask

   task automatic test_forward();
      bus.alu_result_ex = 32'hDEAD_0001;
      bus.wd_mem        = 32'hDEAD_0002;
      bus.wd_wb         = 32'hDEAD_0003;
      set_id(R_OP, 5'd3, 5'd1, 5'd2, 1'b1, 32'h1111_1111, 32'h2222_2222, 2'b01, 2'b00);
      tick();
      tests_run++; if (bus.rd1_ex !== 32'hDEAD_0001) begin tests_failed++; $display("FAIL fwdA_ex: got %h want DEAD0001", bus.rd1_ex); end
      tests_run++; if (bus.rd2_ex !== 32'h2222_2222) begin tests_failed++; $display("FAIL fwdB_none: got %h want 22222222", bus.rd2_ex); end
      tests_run++; if (bus.valid_ex !== 1'b1 || bus.rd_ex !== 5'd3) begin tests_failed++; $display("FAIL fwd_load: got valid=%b rd=%0d want 1/3", bus.valid_ex, bus.rd_ex); end
      tests_run++; if (bus.instr_ex !== mk(R_OP, 5'd3, 5'd1, 5'd2) || bus.pc_ex !== 32'h1003) begin tests_failed++; $display("FAIL fwd_fields: got instr=%h pc=%h", bus.instr_ex, bus.pc_ex); end
      $display("[TB] forward A=01: rd1_ex=%h", bus.rd1_ex);
      set_id(R_OP, 5'd4, 5'd1, 5'd2, 1'b1, 32'h1111_1111, 32'h2222_2222, 2'b10, 2'b01);
      tick();
      tests_run++; if (bus.rd1_ex !== 32'hDEAD_0002) begin tests_failed++; $display("FAIL fwdA_mem: got %h want DEAD0002", bus.rd1_ex); end
      tests_run++; if (bus.rd2_ex !== 32'hDEAD_0001) begin tests_failed++; $display("FAIL fwdB_ex: got %h want DEAD0001", bus.rd2_ex); end
      $display("[TB] forward A=10 B=01: rd1_ex=%h rd2_ex=%h", bus.rd1_ex, bus.rd2_ex);
      set_id(R_OP, 5'd8, 5'd1, 5'd2, 1'b1, 32'h1111_1111, 32'h2222_2222, 2'b11, 2'b10);
      tick();
      tests_run++; if (bus.rd1_ex !== 32'hDEAD_0003) begin tests_failed++; $display("FAIL fwdA_wb: got %h want DEAD0003", bus.rd1_ex); end
      tests_run++; if (bus.rd2_ex !== 32'hDEAD_0002) begin tests_failed++; $display("FAIL fwdB_mem: got %h want DEAD0002", bus.rd2_ex); end
      tests_run++; if (bus.rd_ex !== 5'd8) begin tests_failed++; $display("FAIL back_to_back_rd: got %0d want 8", bus.rd_ex); end
      $display("[TB] forward A=11 B=10: rd1_ex=%h rd2_ex=%h", bus.rd1_ex, bus.rd2_ex);
   endtask

   task automatic test_load_use();
      set_id(LW_OP, 5'd5, 5'd2, 5'd0, 1'b1, 32'h0, 32'h0, 2'b00, 2'b00);
      tick();
      set_id(R_OP, 5'd6, 5'd5, 5'd7, 1'b1, 32'h5555_5555, 32'h7777_7777, 2'b00, 2'b00);
      #1;
      tests_run++; if (bus.stall !== 1'b1) begin tests_failed++; $display("FAIL lu_stall: got %b want 1", bus.stall); end
      tick();
      tests_run++; if (bus.valid_ex !== 1'b0 || bus.instr_ex !== 32'h13) begin tests_failed++; $display("FAIL lu_bubble: got valid=%b instr=%h want 0/00000013", bus.valid_ex, bus.instr_ex); end
      tests_run++; if (bus.stall_cnt !== 3'd1) begin tests_failed++; $display("FAIL lu_cnt: got %0d want 1", bus.stall_cnt); end
      tests_run++; if (bus.stall !== 1'b0) begin tests_failed++; $display("FAIL lu_one_cycle: got %b want 0", bus.stall); end
      bus.wd_mem   = 32'hCAFE_0005;
      bus.forwardA = 2'b10;
      tick();
      tests_run++; if (bus.valid_ex !== 1'b1 || bus.rd_ex !== 5'd6) begin tests_failed++; $display("FAIL lu_enter: got valid=%b rd=%0d want 1/6", bus.valid_ex, bus.rd_ex); end
      tests_run++; if (bus.rd1_ex !== 32'hCAFE_0005) begin tests_failed++; $display("FAIL lu_fwd: got %h want CAFE0005", bus.rd1_ex); end
      tests_run++; if (bus.stall_cnt !== 3'd1) begin tests_failed++; $display("FAIL lu_cnt_hold: got %0d want 1", bus.stall_cnt); end
      $display("[TB] load-use: one bubble, add got %h", bus.rd1_ex);
   endtask

   task automatic test_flush();
      set_id(R_OP, 5'd9, 5'd1, 5'd2, 1'b1, 32'h1, 32'h2, 2'b00, 2'b00);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      tests_run++; if (bus.valid_ex !== 1'b0 || bus.we_rf_ex !== 1'b0) begin tests_failed++; $display("FAIL fl_bubble: got valid=%b we=%b want 0/0", bus.valid_ex, bus.we_rf_ex); end
      tests_run++; if (bus.rd_ex !== 5'd0 || bus.ctrl_ex !== 16'h0) begin tests_failed++; $display("FAIL fl_fields: got rd=%0d ctrl=%h want 0/0", bus.rd_ex, bus.ctrl_ex); end
      tests_run++; if (bus.flush_cnt !== 3'd1) begin tests_failed++; $display("FAIL fl_cnt: got %0d want 1", bus.flush_cnt); end
      $display("[TB] flush: bubble, flush_cnt=%0d", bus.flush_cnt);
      set_id(LW_OP, 5'd5, 5'd2, 5'd0, 1'b1, 32'h0, 32'h0, 2'b00, 2'b00);
      tick();
      set_id(R_OP, 5'd6, 5'd5, 5'd7, 1'b1, 32'h1, 32'h2, 2'b00, 2'b00);
      bus.flush = 1'b1;
      #1;
      tests_run++; if (bus.stall !== 1'b1) begin tests_failed++; $display("FAIL fs_stall: got %b want 1", bus.stall); end
      tick();
      bus.flush = 1'b0;
      tests_run++; if (bus.flush_cnt !== 3'd2) begin tests_failed++; $display("FAIL fs_flush_cnt: got %0d want 2", bus.flush_cnt); end
      tests_run++; if (bus.stall_cnt !== 3'd1) begin tests_failed++; $display("FAIL fs_stall_cnt: got %0d want 1", bus.stall_cnt); end
      tests_run++; if (bus.valid_ex !== 1'b0) begin tests_failed++; $display("FAIL fs_valid: got %b want 0", bus.valid_ex); end
      $display("[TB] flush+stall: flush_cnt=%0d stall_cnt=%0d", bus.flush_cnt, bus.stall_cnt);
   endtask

   task automatic test_no_forward();
      set_id(LUI_OP, 5'd10, 5'd1, 5'd2, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 2'b01, 2'b11);
      tick();
      tests_run++; if (bus.rd1_ex !== 32'h1234_5678) begin tests_failed++; $display("FAIL lui_rd1: got %h want 12345678", bus.rd1_ex); end
      tests_run++; if (bus.rd2_ex !== 32'h9ABC_DEF0) begin tests_failed++; $display("FAIL lui_rd2: got %h want 9ABCDEF0", bus.rd2_ex); end
      $display("[TB] lui stale codes: rd1_ex=%h rd2_ex=%h", bus.rd1_ex, bus.rd2_ex);
      // store: A forwards, B keeps RF data
      set_id(S_OP, 5'd0, 5'd1, 5'd2, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 2'b01, 2'b01);
      tick();
      tests_run++; if (bus.rd1_ex !== 32'hDEAD_0001) begin tests_failed++; $display("FAIL sw_rd1: got %h want DEAD0001", bus.rd1_ex); end
      tests_run++; if (bus.rd2_ex !== 32'h9ABC_DEF0) begin tests_failed++; $display("FAIL sw_rd2: got %h want 9ABCDEF0", bus.rd2_ex); end
      $display("[TB] sw: rd1_ex=%h rd2_ex=%h", bus.rd1_ex, bus.rd2_ex);
   endtask

   task automatic test_boundary();
      set_id(LW_OP, 5'd0, 5'd2, 5'd0, 1'b1, 32'h0, 32'h0, 2'b00, 2'b00);
      tick();
      set_id(R_OP, 5'd6, 5'd0, 5'd0, 1'b1, 32'h1, 32'h2, 2'b00, 2'b00);
      #1;
      tests_run++; if (bus.stall !== 1'b0) begin tests_failed++; $display("FAIL lw_x0: got %b want 0", bus.stall); end
      set_id(LW_OP, 5'd5, 5'd2, 5'd0, 1'b1, 32'h0, 32'h0, 2'b00, 2'b00);
      tick();
      set_id(LUI_OP, 5'd6, 5'd5, 5'd5, 1'b1, 32'h1, 32'h2, 2'b00, 2'b00);
      #1;
      tests_run++; if (bus.stall !== 1'b0) begin tests_failed++; $display("FAIL lui_no_rs: got %b want 0", bus.stall); end
      set_id(S_OP, 5'd0, 5'd1, 5'd5, 1'b0, 32'h1, 32'h2, 2'b00, 2'b00);
      #1;
      tests_run++; if (bus.stall !== 1'b1) begin tests_failed++; $display("FAIL sw_rs2: got %b want 1", bus.stall); end
      tick();
      tests_run++; if (bus.stall_cnt !== 3'd2) begin tests_failed++; $display("FAIL bd_cnt: got %0d want 2", bus.stall_cnt); end
      $display("[TB] boundary: stall_cnt=%0d", bus.stall_cnt);
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 7; i++) begin
         set_id(LW_OP, 5'd5, 5'd2, 5'd0, 1'b1, 32'h0, 32'h0, 2'b00, 2'b00);
         tick();
         set_id(R_OP, 5'd6, 5'd5, 5'd7, 1'b1, 32'h1, 32'h2, 2'b00, 2'b00);
         tick();
         if (i == 4) begin
            tests_run++; if (bus.stall_cnt !== 3'd7) begin tests_failed++; $display("FAIL sat_reach: got %0d want 7", bus.stall_cnt); end
         end
      end
      tests_run++; if (bus.stall_cnt !== 3'd7) begin tests_failed++; $display("FAIL sat_stall: got %0d want 7", bus.stall_cnt); end
      $display("[TB] stall_cnt saturated at %0d", bus.stall_cnt);
      bus.flush = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      bus.flush = 1'b0;
      tests_run++; if (bus.flush_cnt !== 3'd7) begin tests_failed++; $display("FAIL sat_flush: got %0d want 7", bus.flush_cnt); end
      $display("[TB] flush_cnt saturated at %0d", bus.flush_cnt);
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst          = 1'b1;
      bus.flush         = 1'b0;
      bus.alu_result_ex = 32'h0;
      bus.wd_mem        = 32'h0;
      bus.wd_wb         = 32'h0;
      set_id(R_OP, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0, 2'b00, 2'b00);
      tick();
      tick();
      rst = 1'b0;
      tests_run++; if (bus.valid_ex !== 1'b0 || bus.instr_ex !== 32'h13) begin tests_failed++; $display("FAIL init_reset: got valid=%b instr=%h", bus.valid_ex, bus.instr_ex); end
      test_reset();
      test_forward();
      test_load_use();
      test_flush();
      test_no_forward();
      test_boundary();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
